// File: rtl/rtc_core_malrm_if.sv
// rtc_core_malrm_if: control/status bundle between the CSR wrapper (master) and the RTC core (slave)
//   en_i, psc_i                      counting enable and prescaler divide value
//   cnt_wr_i, cnt_wdata_i            counter load
//   alrm_wr_i, alrm_idx_i,
//   alrm_cmp_i, alrm_per_i           alarm channel compare/period write
//   flag_clr_i, ie_i                 write-1-to-clear and interrupt enable per flag
//   cnt_o, tick_o, flag_o, irq_o     counter, tick pulse, sticky flags, interrupt
interface rtc_core_malrm_if #(
    parameter int CNT_W    = 32,
    parameter int PSC_W    = 20,
    parameter int NUM_ALRM = 4,
    parameter int IDX_W    = 2
);
    logic                en_i;
    logic [PSC_W-1:0]    psc_i;
    logic                cnt_wr_i;
    logic [CNT_W-1:0]    cnt_wdata_i;
    logic                alrm_wr_i;
    logic [IDX_W-1:0]    alrm_idx_i;
    logic [CNT_W-1:0]    alrm_cmp_i;
    logic [CNT_W-1:0]    alrm_per_i;
    logic [NUM_ALRM+1:0] flag_clr_i;
    logic [NUM_ALRM+1:0] ie_i;
    logic [CNT_W-1:0]    cnt_o;
    logic                tick_o;
    logic [NUM_ALRM+1:0] flag_o;
    logic                irq_o;
    modport master (
        output en_i, psc_i, cnt_wr_i, cnt_wdata_i, alrm_wr_i, alrm_idx_i,
               alrm_cmp_i, alrm_per_i, flag_clr_i, ie_i,
        input  cnt_o, tick_o, flag_o, irq_o
    );
    modport slave (
        input  en_i, psc_i, cnt_wr_i, cnt_wdata_i, alrm_wr_i, alrm_idx_i,
               alrm_cmp_i, alrm_per_i, flag_clr_i, ie_i,
        output cnt_o, tick_o, flag_o, irq_o
    );
endinterface

// File: rtl/rtc_core_malrm.sv
// rtc_core_malrm: prescaled up-counter with one-shot/periodic alarm comparators, sticky flags and maskable irq
//   clk_i  core clock
//   rst_i  asynchronous active-high reset
//   bus    rtc_core_malrm_if.slave (control inputs, counter/tick/flag/irq outputs)
module rtc_core_malrm #(
    parameter int CNT_W    = 32,
    parameter int PSC_W    = 20,
    parameter int NUM_ALRM = 4,
    parameter int IDX_W    = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    rtc_core_malrm_if.slave  bus
);
    logic [PSC_W-1:0]    psc_cnt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                tick_q;
    logic [NUM_ALRM+1:0] flag;
    logic [CNT_W-1:0]    cmp [NUM_ALRM];
    logic [CNT_W-1:0]    per [NUM_ALRM];
    logic                tick;
    logic                adv;
    logic [NUM_ALRM-1:0] wsel;
    logic [NUM_ALRM-1:0] match;
    // >= rather than == so lowering psc_i below the running count ticks at once
    assign tick    = bus.en_i && psc_cnt >= bus.psc_i;
    // a counter load swallows a coincident tick entirely
    assign adv     = tick && !bus.cnt_wr_i;
    assign cnt_inc = cnt + 1'b1;
    // out-of-range indices decode to no channel, so they are ignored
    for (genvar k = 0; k < NUM_ALRM; k++) begin : g_ch
        assign wsel[k]  = bus.alrm_wr_i && bus.alrm_idx_i == IDX_W'(k);
        assign match[k] = adv && !wsel[k] && cnt_inc == cmp[k];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psc_cnt <= '0;
            cnt     <= '0;
            tick_q  <= 1'b0;
            flag    <= '0;
            for (int i = 0; i < NUM_ALRM; i++) begin
                cmp[i] <= '1;
                per[i] <= '0;
            end
        end else begin
            if (bus.cnt_wr_i)
                psc_cnt <= '0;
            else if (bus.en_i)
                psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
            if (bus.cnt_wr_i)
                cnt <= bus.cnt_wdata_i;
            else if (adv)
                cnt <= cnt_inc;
            tick_q <= adv;
            // set has priority over a same-cycle clear
            flag <= (flag & ~bus.flag_clr_i) | {adv, adv && (&cnt), match};
            for (int i = 0; i < NUM_ALRM; i++) begin
                if (wsel[i]) begin
                    cmp[i] <= bus.alrm_cmp_i;
                    per[i] <= bus.alrm_per_i;
                end else if (match[i] && per[i] != '0) begin
                    cmp[i] <= cmp[i] + per[i];
                end
            end
        end
    end
    assign bus.cnt_o  = cnt;
    assign bus.tick_o = tick_q;
    assign bus.flag_o = flag;
    assign bus.irq_o  = |(flag & bus.ie_i);
endmodule

// File: doc/rtc_core_malrm.md
Name: rtc_core_malrm

Overview:
Parametrised real-time-counter core: a programmable prescaler drives a CNT_W-bit up-counter with NUM_ALRM independent alarm comparators. Each comparator runs in one-shot or periodic auto-reload mode. Sticky status flags feed a maskable interrupt. The core sits behind the bus register wrapper, which maps ports to CSRs, and runs entirely in one clock domain; any CDC is the wrapper's job.

Parameters:
CNT_W  32  width of main counter, alarm compare and period values
PSC_W  20  width of prescaler divide value
NUM_ALRM  4  number of alarm channels (1..16)
IDX_W  2  width of alarm index, equals clog2(NUM_ALRM) (minimum 1)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  counting enable
psc_i  in  PSC_W  divide value; tick period = psc_i+1 clk_i cycles
cnt_wr_i  in  1  load counter strobe
cnt_wdata_i  in  CNT_W  counter load value
alrm_wr_i  in  1  alarm channel write strobe
alrm_idx_i  in  IDX_W  alarm channel selected by alrm_wr_i
alrm_cmp_i  in  CNT_W  compare value to write
alrm_per_i  in  CNT_W  reload period to write (0 = one-shot)
flag_clr_i  in  NUM_ALRM+2  write-1-to-clear per status flag
ie_i  in  NUM_ALRM+2  interrupt enable per flag
cnt_o  out  CNT_W  current counter value
tick_o  out  1  one-cycle pulse on each counter increment
flag_o  out  NUM_ALRM+2  sticky flags: [NUM_ALRM-1:0] alarm k, [NUM_ALRM] overflow, [NUM_ALRM+1] tick
irq_o  out  1  OR of (flag_o & ie_i), combinational from registered flags

Behaviour:
- Reset values: prescaler count 0; cnt_o 0; tick_o 0; flag_o 0; irq_o 0; every alarm cmp all-ones; every period 0.
- Prescaler: while en_i=1, psc_cnt increments each cycle. When psc_cnt >= psc_i, tick fires and psc_cnt returns to 0.
  - The >= compare means lowering psc_i mid-count takes effect next cycle, with no runaway.
  - psc_i=0 ticks every cycle.
- en_i=0: psc_cnt and cnt hold; no ticks fire; flags and clears still operate.
- Tick cycle: cnt <= cnt+1 and tick_o=1 on the next cycle. Mod 2^CNT_W wrap: all-ones -> 0 sets flag[NUM_ALRM] (overflow). Every tick sets flag[NUM_ALRM+1].
- Alarm k match: evaluated only on a tick, against the incremented value (cnt+1 == cmp[k]). Effects:
  - flag[k] set in the same edge as the counter update.
  - If per[k]!=0, cmp[k] <= cmp[k]+per[k] (mod 2^CNT_W) on that edge.
  - If per[k]==0, cmp[k] is unchanged, so the alarm fires again only after a full counter wrap.
  - Multiple channels may match on the same tick; all set.
- cnt_wr_i: cnt <= cnt_wdata_i and psc_cnt <= 0. It wins over a same-cycle tick: no increment, no tick_o, no overflow, tick or alarm flag from that tick. A loaded value never causes a match by itself.
- alrm_wr_i: cmp[idx] <= alrm_cmp_i and per[idx] <= alrm_per_i. It wins over a same-cycle match or reload on that channel; flag[idx] is not set that cycle. Other channels are unaffected. An idx >= NUM_ALRM is ignored.
- Flags: sticky until cleared by flag_clr_i bit =1. Set and clear on the same flag in the same cycle: set wins. Clearing has no effect on counters.
- irq_o follows flag_o one cycle after the set edge, i.e. a combinational function of registered flags and ie_i. Changing ie_i affects irq_o in the same cycle.
- Reset mid-operation: asynchronous clear of all state to the reset values. First tick after release needs psc_i+1 enabled cycles.
- Sequential elements: psc_cnt, cnt, tick_o, flags, cmp/per arrays. No combinational path from inputs to outputs other than ie_i to irq_o.

Test Plan:
- Reset, en_i=1, psc_i=3 -> tick_o pulses every 4 cycles; after 40 cycles cnt_o=10 and flag[NUM_ALRM+1]=1; with en_i=0 cnt_o holds at 10 for 20 cycles.
- Load cnt=0xFFFF_FFFE, psc_i=0 -> two ticks give cnt_o=0 with flag[NUM_ALRM]=1. With ie_i[NUM_ALRM]=1, irq_o=1; clear via flag_clr_i -> irq_o=0 the next cycle.
- Alarm 0 cmp=5 per=0 and alarm 2 cmp=5 per=3, psc_i=0, start cnt=0 -> flag[0] and flag[2] set on the same edge cnt becomes 5. cmp[2] reads back as 8 (flag[2] re-fires at 8, 11, 14); flag[0] does not re-fire.
- cnt_wr_i asserted on the same cycle as a tick with cnt_wdata=100 -> cnt_o=100, no tick_o, no flag set; next tick gives 101.
- flag_clr_i[1]=1 in the same cycle alarm 1 matches -> flag[1]=1 remains. alrm_wr_i to channel 1 on a matching cycle -> flag[1] not set and new cmp loaded.
- Assert rst_i asynchronously mid-count (cnt=37, flags=0x3F) -> all outputs 0 immediately; after release with psc_i=1, first tick_o arrives two cycles later.
